// File: rtl/ws_seq_pkg.sv
// Shared types, register map and address decode for the ws2812b frame sequencer.
package ws_seq_pkg;

  localparam logic [3:0] ADDR_CTRL     = 4'd0;
  localparam logic [3:0] ADDR_PTR      = 4'd1;
  localparam logic [3:0] ADDR_DATA     = 4'd2;
  localparam logic [3:0] ADDR_LEN      = 4'd3;
  localparam logic [3:0] ADDR_PAL_BASE = 4'd4;

  localparam int CTRL_START    = 0;
  localparam int CTRL_LATCH_EN = 1;
  localparam int CTRL_ABORT    = 2;
  localparam int CTRL_AUTO_EN  = 3;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND
  } state_t;

  typedef logic [23:0] grb_t;
  typedef logic [1:0]  pal_idx_t;

  typedef struct packed {
    logic       hit;
    pal_idx_t   entry;
    logic [1:0] byte_sel;  // 0 = G, 1 = R, 2 = B
  } pal_sel_t;

  // Palette occupies addresses 4..15 as three consecutive bytes per entry.
  function automatic pal_sel_t decode_pal(input logic [3:0] addr);
    pal_sel_t   sel;
    logic [3:0] off;
    off          = addr - ADDR_PAL_BASE;
    sel.hit      = (addr >= ADDR_PAL_BASE);
    sel.entry    = pal_idx_t'(off / 4'd3);
    sel.byte_sel = 2'(off % 4'd3);
    return sel;
  endfunction

endpackage

// File: rtl/ws2812b_frame_sequencer_if.sv
// Register bus plus pixel stream of the frame sequencer; the sequencer uses the slave side.
interface ws2812b_frame_sequencer_if;
  import ws_seq_pkg::*;

  logic [3:0] address;
  logic       data_write;
  logic [7:0] data_in;
  logic [7:0] data_out;
  grb_t       pix_data;
  logic       pix_valid;
  logic       pix_latch;
  logic       pix_ready;
  logic       busy;

  modport master (
    output address, data_write, data_in, pix_ready,
    input  data_out, pix_data, pix_valid, pix_latch, busy
  );

  modport slave (
    input  address, data_write, data_in, pix_ready,
    output data_out, pix_data, pix_valid, pix_latch, busy
  );

endinterface

// File: rtl/ws_seq_palette.sv
// Four-entry GRB palette: byte writes and byte readback from the bus, full-word read by colour index.
module ws_seq_palette
  import ws_seq_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       we,
  input  pal_idx_t   sel_entry,
  input  logic [1:0] sel_byte,
  input  logic [7:0] wdata,
  input  pal_idx_t   rd_idx,
  output grb_t       rd_grb,
  output logic [7:0] rd_byte
);

  grb_t pal [4];

  // NOTE: the palette must read 0 after reset, so this small array is built from resettable flops
  // rather than a RAM; non-blocking assignments keep every flop update race-free.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 4; k++) pal[k] <= '0;
    end else if (we) begin
      case (sel_byte)
        2'd0:    pal[sel_entry][23:16] <= wdata;
        2'd1:    pal[sel_entry][15:8]  <= wdata;
        default: pal[sel_entry][7:0]   <= wdata;
      endcase
    end
  end

  assign rd_grb = pal[rd_idx];

  // NOTE: assigning a default before the case keeps this purely combinational (no latch).
  always_comb begin
    rd_byte = pal[sel_entry][7:0];
    case (sel_byte)
      2'd0:    rd_byte = pal[sel_entry][23:16];
      2'd1:    rd_byte = pal[sel_entry][15:8];
      default: ;
    endcase
  end

endmodule

// File: rtl/ws2812b_frame_sequencer.sv
// Streams LEN palette-indexed pixels to the ws2812b serializer with valid/ready and an end-of-frame latch.
// Optional auto-refresh timer is built only when WS_SEQ_AUTOREFRESH_EN is defined.
module ws2812b_frame_sequencer
  import ws_seq_pkg::*;
#(
  parameter int NUM_PIXELS     = 16,
  parameter int REFRESH_CYCLES = 64000
) (
  input logic                      clk,
  input logic                      reset,
  ws2812b_frame_sequencer_if.slave bus
);

  localparam int PTR_W = $clog2(NUM_PIXELS);
  localparam int LEN_W = PTR_W + 1;

  if (NUM_PIXELS < 2 || NUM_PIXELS > 64 || REFRESH_CYCLES < 2) begin : g_bad_cfg
    $error("ws2812b_frame_sequencer: NUM_PIXELS must be 2..64 and REFRESH_CYCLES >= 2");
  end

  state_t           state, state_next;
  logic [PTR_W-1:0] ptr, idx;
  logic [LEN_W-1:0] len;
  logic             latch_en, auto_en, auto_fire;
  pal_idx_t         buf_mem [NUM_PIXELS];
  grb_t             pix_data_q, pal_grb;
  logic [7:0]       pal_byte;
  pal_sel_t         pal_sel;
  logic             busy, idle, reg_wr, ctrl_wr, abort, start_cpu, start, xfer, last_pix;

  assign pal_sel   = decode_pal(bus.address);
  assign busy      = (state != IDLE);
  assign idle      = ~busy;
  // Configuration is frozen for the duration of a frame; only CTRL ABORT gets through.
  assign reg_wr    = bus.data_write & idle;
  assign ctrl_wr   = bus.data_write && (bus.address == ADDR_CTRL);
  assign abort     = ctrl_wr & bus.data_in[CTRL_ABORT];
  assign start_cpu = ctrl_wr & bus.data_in[CTRL_START];
  assign start     = idle & ~abort & (start_cpu | auto_fire) & (len != '0);
  assign xfer      = (state == SEND) & bus.pix_ready;
  assign last_pix  = ({1'b0, idx} == len - LEN_W'(1));

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = LOAD;
      LOAD:    state_next = SEND;
      SEND:    if (bus.pix_ready) state_next = last_pix ? IDLE : LOAD;
      default: state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      pix_data_q <= '0;
    end else begin
      state <= state_next;
      if (start) idx <= '0;
      else if (xfer && !last_pix) idx <= idx + PTR_W'(1);
      if (state == LOAD) pix_data_q <= pal_grb;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr      <= '0;
      len      <= '0;
      latch_en <= 1'b0;
      for (int i = 0; i < NUM_PIXELS; i++) buf_mem[i] <= '0;
    end else if (reg_wr) begin
      case (bus.address)
        ADDR_CTRL: latch_en <= bus.data_in[CTRL_LATCH_EN];
        ADDR_PTR:  ptr <= PTR_W'(bus.data_in % NUM_PIXELS);
        ADDR_DATA: begin
          buf_mem[ptr] <= bus.data_in[1:0];
          ptr <= (ptr == PTR_W'(NUM_PIXELS - 1)) ? '0 : ptr + PTR_W'(1);
        end
        ADDR_LEN:  len <= (bus.data_in > 8'(NUM_PIXELS)) ? LEN_W'(NUM_PIXELS)
                                                         : LEN_W'(bus.data_in);
        default:   ;
      endcase
    end
  end

  ws_seq_palette u_palette (
    .clk       (clk),
    .reset     (reset),
    .we        (reg_wr & pal_sel.hit),
    .sel_entry (pal_sel.entry),
    .sel_byte  (pal_sel.byte_sel),
    .wdata     (bus.data_in),
    .rd_idx    (buf_mem[idx]),
    .rd_grb    (pal_grb),
    .rd_byte   (pal_byte)
  );

`ifdef WS_SEQ_AUTOREFRESH_EN
  logic [31:0] refresh_timer;
  logic        frame_end;

  assign frame_end = busy & (state_next == IDLE);
  assign auto_fire = (refresh_timer == '0) & auto_en;

  // The timer parks at 0 until the triggered frame ends and reloads it.
  always_ff @(posedge clk) begin
    if (reset) begin
      refresh_timer <= 32'(REFRESH_CYCLES - 1);
      auto_en       <= 1'b0;
    end else begin
      if (frame_end) refresh_timer <= 32'(REFRESH_CYCLES - 1);
      else if (idle && refresh_timer != '0) refresh_timer <= refresh_timer - 32'd1;
      if (reg_wr && bus.address == ADDR_CTRL) auto_en <= bus.data_in[CTRL_AUTO_EN];
    end
  end
`else
  assign auto_fire = 1'b0;
  assign auto_en   = 1'b0;
`endif

  always_comb begin
    bus.data_out = pal_byte;
    case (bus.address)
      ADDR_CTRL: bus.data_out = {busy, 3'b000, auto_en, 1'b0, latch_en, 1'b0};
      ADDR_PTR:  bus.data_out = 8'(ptr);
      ADDR_DATA: bus.data_out = {6'b0, buf_mem[ptr]};
      ADDR_LEN:  bus.data_out = 8'(len);
      default:   ;
    endcase
  end

  assign bus.pix_data  = pix_data_q;
  assign bus.pix_valid = (state == SEND);
  assign bus.pix_latch = (state == SEND) & latch_en & last_pix;
  assign bus.busy      = busy;

endmodule
